log_reader: RTL and testbench

//  Consumer for the FIR capture BRAM. On a start pulse it sweeps read addresses from 0 and

---
 rtl/log_reader.sv | 124 ++++++++++++
 tb/tb_log_reader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/log_reader.sv
// log_reader: sweeps the FIR capture BRAM from address 0 and streams each 13-bit sample out on valid/ready
//
// Ports
//   clock        system clock, rising edge
//   i_reset      synchronous active-high reset; aborts a sweep without o_done
//   i_start      1-cycle pulse starting a sweep, ignored unless idle
//   i_length     samples to read, latched on an accepted start; 0 (or >= 2**NB_ADDR) reads 2**NB_ADDR
//   o_ram_addr   BRAM read address
//   o_ram_rd_en  BRAM read enable; data is on i_ram_data the following cycle
//   i_ram_data   BRAM read data; only the low NB_SAMPLE bits are used
//   o_data       output sample, held while o_valid waits for i_ready
//   o_valid      o_data valid
//   i_ready      downstream accepts; a transfer is o_valid & i_ready
//   o_busy       sweep in progress
//   o_done       1-cycle pulse the cycle after the final transfer
//   o_peak       largest |sample| of the sweep (present only when LOG_PEAK_EN is defined)
//
// Build option: define LOG_PEAK_EN to add o_peak and its tracking logic.
module log_reader #(
  parameter int NB_ADDR   = 11,
  parameter int NB_RAM    = 32,
  parameter int NB_SAMPLE = 13
) (
  input  logic                 clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [NB_ADDR:0]     i_length,
  output logic [NB_ADDR-1:0]   o_ram_addr,
  output logic                 o_ram_rd_en,
  input  logic [NB_RAM-1:0]    i_ram_data,
  output logic [NB_SAMPLE-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_busy,
  output logic                 o_done
`ifdef LOG_PEAK_EN
  ,
  output logic [NB_SAMPLE-1:0] o_peak
`endif
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  localparam logic [NB_ADDR:0] ONE = {{NB_ADDR{1'b0}}, 1'b1};
  localparam logic [NB_ADDR:0] TOP = {1'b1, {NB_ADDR{1'b0}}};
  state_t state;
  logic [NB_ADDR:0] len, rd_cnt, xf_cnt;
  logic [NB_SAMPLE-1:0] buf1, smp;
  logic [1:0] cnt;
  logic [2:0] occ;
  logic pend, pop, unused_ram_bits;
  assign smp = i_ram_data[NB_SAMPLE-1:0];
  assign unused_ram_bits = ^i_ram_data[NB_RAM-1:NB_SAMPLE];
  assign o_valid = cnt != 2'd0;
  assign pop = o_valid & i_ready;
  // Occupancy counts this cycle's pop as already gone so a steady stream
  // sustains one read per cycle while a stall still caps the buffer at two.
  assign occ = {1'b0, cnt} + {2'b0, pend} - {2'b0, pop};
  assign o_ram_rd_en = state == READ && occ < 3'd2;
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state      <= IDLE;
      len        <= '0;
      rd_cnt     <= '0;
      xf_cnt     <= '0;
      o_ram_addr <= '0;
      o_data     <= '0;
      buf1       <= '0;
      cnt        <= '0;
      pend       <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      pend   <= o_ram_rd_en;
      o_done <= 1'b0;
      // o_data is the FIFO head; buf1 is the skid slot behind it.
      if (pop)
        o_data <= cnt == 2'd2 ? buf1 : smp;
      else if (pend && cnt == 2'd0)
        o_data <= smp;
      if (pend && (cnt == 2'd2 || (cnt == 2'd1 && !pop)))
        buf1 <= smp;
      cnt <= cnt + {1'b0, pend} - {1'b0, pop};
      if (pop)
        xf_cnt <= xf_cnt + ONE;
      case (state)
        IDLE: if (i_start) begin
          len        <= (i_length == '0 || i_length[NB_ADDR]) ? TOP : i_length;
          rd_cnt     <= '0;
          xf_cnt     <= '0;
          o_ram_addr <= '0;
          o_busy     <= 1'b1;
          state      <= READ;
        end
        READ: if (o_ram_rd_en) begin
          rd_cnt <= rd_cnt + ONE;
          // The final address is left in place so a full sweep never wraps to 0.
          if (rd_cnt + ONE == len)
            state <= DRAIN;
          else
            o_ram_addr <= o_ram_addr + 1'b1;
        end
        DRAIN: if (pop && xf_cnt + ONE == len) begin
          o_busy <= 1'b0;
          o_done <= 1'b1;
          state  <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef LOG_PEAK_EN
  logic [NB_SAMPLE-1:0] mag;
  // Unsigned magnitude: the most negative sample maps to 2**(NB_SAMPLE-1), which still fits.
  assign mag = o_data[NB_SAMPLE-1] ? -o_data : o_data;
  always_ff @(posedge clock) begin
    if (i_reset)
      o_peak <= '0;
    else if (state == IDLE && i_start)
      o_peak <= '0;
    else if (pop && mag > o_peak)
      o_peak <= mag;
  end
`endif
endmodule

// File: tb/tb_log_reader.sv
// tb_log_reader: scoreboard bench for log_reader with a 1-cycle-latency BRAM model
module tb_log_reader;
  localparam int NA = 4, NR = 32, NS = 13;
  logic clock = 1'b0, i_reset = 1'b1, i_start = 1'b0, i_ready = 1'b1;
  logic [NA:0] i_length = '0;
  logic [NA-1:0] o_ram_addr;
  logic o_ram_rd_en, o_valid, o_busy, o_done;
  logic [NR-1:0] i_ram_data = '0;
  logic [NS-1:0] o_data;
`ifdef LOG_PEAK_EN
  logic [NS-1:0] o_peak;
`endif
  log_reader #(.NB_ADDR(NA), .NB_RAM(NR), .NB_SAMPLE(NS)) dut (
    .clock(clock), .i_reset(i_reset), .i_start(i_start), .i_length(i_length),
    .o_ram_addr(o_ram_addr), .o_ram_rd_en(o_ram_rd_en), .i_ram_data(i_ram_data),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy), .o_done(o_done)
`ifdef LOG_PEAK_EN
    , .o_peak(o_peak)
`endif
  );
  always #5 clock = ~clock;
  logic [NR-1:0] mem [16];
  always @(posedge clock) if (o_ram_rd_en) i_ram_data <= mem[o_ram_addr];
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  int n_chk = 0, n_err = 0;
  logic [NS-1:0] exp_q [$];
  logic [NS-1:0] exp_peak = '0, held = '0;
  logic [NA-1:0] exp_addr = '0;
  int exp_len = 0, issued = 0, xfers = 0, done_cnt = 0, mode = 0, st_cyc = 0;
  int first_rd = -1, first_v = -1, first_x = -1, last_x = -1;
  bit in_rst = 1'b1, stall = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic do_start(input int len);
    int l;
    logic [NS-1:0] s, a;
    l = len == 0 ? 16 : len;
    @(posedge clock); #1;
    exp_len = l; issued = 0; xfers = 0; exp_addr = '0; exp_peak = '0;
    first_rd = -1; first_v = -1; first_x = -1; last_x = -1;
    for (int i = 0; i < l; i++) begin
      s = mem[i][NS-1:0];
      exp_q.push_back(s);
      a = s[NS-1] ? -s : s;
      if (a > exp_peak) exp_peak = a;
    end
    st_cyc = cyc;
    i_start = 1'b1; i_length = 5'(len);
    @(posedge clock); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) @(negedge clock);
    check("done_timeout", 32'(done_cnt != d0), 1);
  endtask

  initial forever begin
    @(posedge clock); #1;
    i_ready = mode == 0 ? 1'b1 : mode == 1 ? ~i_ready : 1'($urandom_range(0, 1));
  end

  initial forever begin
    @(negedge clock);
    if (!in_rst) begin
      if (stall) begin
        check("hold_valid", 32'(o_valid), 1);
        check("hold_data", 32'(o_data), 32'(held));
      end
      if (o_ram_rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        check("occupancy", 32'((issued - xfers - int'(o_valid && i_ready)) < 2), 1);
        check("addr", 32'(o_ram_addr), 32'(exp_addr));
        exp_addr++;
        issued++;
      end
      if (o_valid && first_v < 0) first_v = cyc;
      if (o_valid && i_ready) begin
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
        xfers++;
        if (exp_q.size() == 0) check("extra_sample", 32'(o_data), 32'hFFFF);
        else check("data", 32'(o_data), 32'(exp_q.pop_front()));
      end
      stall = o_valid && !i_ready;
      held = o_data;
      if (o_done) begin
        done_cnt++;
        check("done_gap", 32'(cyc - last_x), 1);
        check("busy_at_done", 32'(o_busy), 0);
        check("xfer_count", 32'(xfers), 32'(exp_len));
        check("read_count", 32'(issued), 32'(exp_len));
        check("leftover", 32'(exp_q.size()), 0);
`ifdef LOG_PEAK_EN
        check("peak", 32'(o_peak), 32'(exp_peak));
`endif
      end
    end
  end

  initial begin
    int d0;
    for (int a = 0; a < 16; a++) mem[a] = {19'($urandom), 13'(a)};
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_rd_en", 32'(o_ram_rd_en), 0);
    check("rst_addr", 32'(o_ram_addr), 0);
    check("rst_data", 32'(o_data), 0);
`ifdef LOG_PEAK_EN
    check("rst_peak", 32'(o_peak), 0);
`endif
    @(posedge clock); #1;
    i_reset = 1'b0; in_rst = 1'b0;
    mode = 0;
    do_start(8);
    wait_done(200);
    check("first_rd", 32'(first_rd), 32'(st_cyc + 1));
    check("latency", 32'(first_v - first_rd), 2);
    check("burst", 32'(last_x - first_x), 7);
    mode = 1;
    do_start(16);
    wait_done(400);
    mode = 2;
    do_start(16);
    wait_done(600);
    mode = 0;
    do_start(0);
    wait_done(400);
    check("full_sweep_reads", 32'(issued), 16);
    do_start(10);
    repeat (4) @(posedge clock);
    #1;
    i_start = 1'b1; i_length = 5'd3;
    @(posedge clock); #1;
    i_start = 1'b0;
    check("busy_after_repulse", 32'(o_busy), 1);
    wait_done(400);
    mode = 2;
    do_start(12);
    for (int i = 0; i < 300 && xfers < 5; i++) @(negedge clock);
    check("reach_sample5", 32'(xfers >= 5), 1);
    @(posedge clock); #1;
    i_reset = 1'b1; in_rst = 1'b1;
    d0 = done_cnt;
    exp_q.delete();
    stall = 1'b0;
    @(posedge clock); #1;
    check("abort_valid", 32'(o_valid), 0);
    check("abort_busy", 32'(o_busy), 0);
    i_reset = 1'b0; in_rst = 1'b0;
    mode = 0;
    repeat (20) @(negedge clock);
    check("abort_no_done", 32'(done_cnt), 32'(d0));
    do_start(4);
    wait_done(200);
    mem[0] = {19'h1ABCD, 13'd12};
    mem[1] = {19'h7FFFF, 13'h1000};
    mem[2] = {19'h00001, 13'd300};
    mem[3] = {19'h55555, 13'd4095};
    do_start(4);
    wait_done(200);
    check("peak_expect", 32'(exp_peak), 4096);
`ifdef LOG_PEAK_EN
    repeat (5) @(negedge clock);
    check("peak_stable", 32'(o_peak), 4096);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
